// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bus bundle between the IFU/LSU requesters, the memory
//                arbiter and the physical memory port.
//                slave  : arbiter view (takes requests, drives responses and
//                         the memory strobes).
//                master : environment view (drives requests, responses
//                         readiness and memory read data).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IFU side (read-only)
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_rdata;

    // LSU side (read/write)
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [7:0]        lsu_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_rdata;

    // Physical memory port
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one physical memory port between the IFU (read-only)
//                and the LSU (read/write). One transaction is outstanding at
//                a time; round-robin between the two on conflict. The access
//                is a single-cycle strobe, followed by a fixed LATENCY wait
//                before the response is presented to the owner.
//  Ports       : clk  - core clock
//                rst  - synchronous active-high reset
//                bus  - mem_arbiter_if.slave: IFU/LSU request+response
//                       handshakes and the physical memory port
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2     // legal range 1..15
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic              c_ifu        = 1'b0;
    localparam logic              c_lsu        = 1'b1;
    localparam logic [3:0]        c_latency    = 4'(LATENCY);
    localparam logic [ADDR_W-1:0] c_align_mask = ~(ADDR_W'(3));

    state_t            state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;   // requester served most recently
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic w_grant_ifu;
    logic w_grant_lsu;

    // Round-robin: on conflict the requester that was not served last wins.
    assign w_grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || (last_q == c_ifu));
    assign w_grant_ifu = bus.ifu_req_valid && !w_grant_lsu;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            owner_q <= c_ifu;
            last_q  <= c_lsu;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        owner_d            = owner_q;
        last_d             = last_q;
        rdata_d            = rdata_q;
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        bus.ifu_rdata      = '0;
        bus.lsu_rdata      = '0;
        bus.mem_ren        = 1'b0;
        bus.mem_wen        = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        bus.mem_wmask      = 8'd0;

        case (state_q)
            S_IDLE: begin
                bus.ifu_req_ready = w_grant_ifu;
                bus.lsu_req_ready = w_grant_lsu;
                if (w_grant_lsu && bus.lsu_wen) begin
                    // Writes go out unaligned; the mask selects the lanes.
                    bus.mem_wen   = 1'b1;
                    bus.mem_addr  = bus.lsu_addr;
                    bus.mem_wdata = bus.lsu_wdata;
                    bus.mem_wmask = bus.lsu_wmask;
                    rdata_d       = '0;
                end else if (w_grant_lsu || w_grant_ifu) begin
                    // Reads are word-aligned; memory answers in the same cycle.
                    bus.mem_ren  = 1'b1;
                    bus.mem_addr = (w_grant_lsu ? bus.lsu_addr : bus.ifu_addr) & c_align_mask;
                    rdata_d      = bus.mem_rdata;
                end
                if (w_grant_lsu || w_grant_ifu) begin
                    owner_d = w_grant_lsu ? c_lsu : c_ifu;
                    cnt_d   = c_latency;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (owner_q == c_lsu) begin
                    bus.lsu_resp_valid = 1'b1;
                    bus.lsu_rdata      = rdata_q;
                    if (bus.lsu_resp_ready) begin
                        last_d  = c_lsu;
                        state_d = S_IDLE;
                    end
                end else begin
                    bus.ifu_resp_valid = 1'b1;
                    bus.ifu_rdata      = rdata_q;
                    if (bus.ifu_resp_ready) begin
                        last_d  = c_ifu;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
